// File: rtl/div_mon_pkg.sv
// rtl/div_mon_pkg.sv - shared constants, types and helpers for div_clk_monitor
// Purpose: default widths, run-length and sample-pair types, saturating increment.
// Ports: none (package).
package div_mon_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;

  typedef logic [CNT_W_DEF-1:0] half_cnt_t;

  // h: clk_div during the clk-high phase, l: during the following clk-low phase
  typedef struct packed {
    logic h;
    logic l;
  } sample_pair_t;

  function automatic int sat_inc(input int v, input int max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// rtl/div_clk_monitor_if.sv - control, stimulus and result bundle of div_clk_monitor
// Purpose: groups enable, divided clock, expectations and measurement results.
// Ports (master drives / slave receives):
//   en, clk_div, exp_high, exp_low          master -> slave
//   high_len, low_len, period_len,
//   meas_valid, duty_err, period_err,
//   locked, stuck                           slave -> master
interface div_mon_if
  import div_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             en;
  logic             clk_div;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] exp_low;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W:0]   period_len;
  logic             meas_valid;
  logic             duty_err;
  logic             period_err;
  logic             locked;
  logic             stuck;

  modport master (
    output en, clk_div, exp_high, exp_low,
    input  high_len, low_len, period_len, meas_valid, duty_err, period_err,
           locked, stuck
  );

  modport slave (
    input  en, clk_div, exp_high, exp_low,
    output high_len, low_len, period_len, meas_valid, duty_err, period_err,
           locked, stuck
  );

endinterface

// File: rtl/div_mon_sampler.sv
// rtl/div_mon_sampler.sv - dual-edge capture of the divided clock
// Purpose: samples clk_div on both clk edges and presents one time-ordered pair per posedge.
// Ports:
//   clk      in   source clock
//   rst_n    in   asynchronous active-low reset
//   clk_div  in   divided clock under test
//   pair     out  {h, l} for the clk period that ended at the latest posedge
module div_mon_sampler
  import div_mon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_div,
  output sample_pair_t pair
);

  logic s_n;   // clk-high phase value, captured at negedge
  logic h_q;   // s_n re-timed to posedge so it stays paired with s_p
  logic s_p;   // clk-low phase value, captured at posedge

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) s_n <= 1'b0;
    else        s_n <= clk_div;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= 1'b0;
      s_p <= 1'b0;
    end else begin
      h_q <= s_n;
      s_p <= clk_div;
    end
  end

  assign pair = '{h: h_q, l: s_p};

endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - high/low/period checker for N.5 fractional divider outputs
// Purpose: measures clk_div run lengths in half-cycles of clk, flags duty and period
//          errors against expectations, and declares lock after LOCK_CNT good periods.
// Ports:
//   clk    in   source clock feeding the divider
//   rst_n  in   asynchronous active-low reset
//   mon    slave modport of div_mon_if (en, clk_div, exp_* in; results out)
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  div_mon_if.slave mon
);

  localparam int LW      = $clog2(LOCK_CNT + 1);
  localparam int RUN_MAX = (1 << CNT_W) - 1;

  sample_pair_t pair;

  div_mon_sampler u_sampler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_div (mon.clk_div),
    .pair    (pair)
  );

  logic             prev_q, armed_q, stuck_q, locked_q;
  logic             meas_valid_q, duty_err_q, period_err_q;
  logic [CNT_W-1:0] run_q, hi_acc_q, high_len_q, low_len_q;
  logic [CNT_W:0]   period_len_q;
  logic [LW-1:0]    lock_cnt_q;

  logic             prev_n, armed_n, stuck_n, pub, duty_bad, period_bad;
  logic [CNT_W-1:0] run_n, hi_acc_n, pub_hi, pub_lo;
  logic [LW-1:0]    lock_cnt_n;
  logic [1:0]       smp;

  // Walk the two samples of this clk period in time order (h first).
  always_comb begin
    smp        = {pair.l, pair.h};
    prev_n     = prev_q;
    run_n      = run_q;
    hi_acc_n   = hi_acc_q;
    armed_n    = armed_q;
    pub        = 1'b0;
    pub_hi     = hi_acc_q;
    pub_lo     = run_q;
    for (int i = 0; i < 2; i++) begin
      if (smp[i] == prev_n) begin
        run_n = CNT_W'(sat_inc(int'(run_n), RUN_MAX));
      end else begin
        if (prev_n) begin
          hi_acc_n = run_n;
        end else begin
          // Rising edge closes a full period only once a previous rise was seen.
          if (armed_n) begin
            pub    = 1'b1;
            pub_hi = hi_acc_n;
            pub_lo = run_n;
          end
          armed_n = 1'b1;
        end
        run_n = CNT_W'(1);
      end
      prev_n = smp[i];
    end
    // A saturated run means the period is unmeasurable; force a fresh arm.
    stuck_n = (int'(run_n) == RUN_MAX);
    if (stuck_n) armed_n = 1'b0;

    duty_bad   = (pub_hi != mon.exp_high) || (pub_lo != mon.exp_low);
    period_bad = ({1'b0, pub_hi} + {1'b0, pub_lo}) !=
                 ({1'b0, mon.exp_high} + {1'b0, mon.exp_low});

    lock_cnt_n = lock_cnt_q;
    if (stuck_n || (pub && (duty_bad || period_bad))) lock_cnt_n = '0;
    else if (pub) lock_cnt_n = LW'(sat_inc(int'(lock_cnt_q), LOCK_CNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= 1'b0;
      run_q        <= '0;
      hi_acc_q     <= '0;
      armed_q      <= 1'b0;
      stuck_q      <= 1'b0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      duty_err_q   <= 1'b0;
      period_err_q <= 1'b0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      period_len_q <= '0;
    end else begin
      // prev tracks clk_div even while disabled so re-enable sees true edges.
      prev_q <= prev_n;
      if (!mon.en) begin
        run_q        <= '0;
        armed_q      <= 1'b0;
        stuck_q      <= 1'b0;
        lock_cnt_q   <= '0;
        locked_q     <= 1'b0;
        meas_valid_q <= 1'b0;
        duty_err_q   <= 1'b0;
        period_err_q <= 1'b0;
      end else begin
        run_q        <= run_n;
        hi_acc_q     <= hi_acc_n;
        armed_q      <= armed_n;
        stuck_q      <= stuck_n;
        lock_cnt_q   <= lock_cnt_n;
        locked_q     <= (lock_cnt_n == LW'(LOCK_CNT));
        meas_valid_q <= pub;
        duty_err_q   <= pub && duty_bad;
        period_err_q <= pub && period_bad;
        if (pub) begin
          high_len_q   <= pub_hi;
          low_len_q    <= pub_lo;
          period_len_q <= {1'b0, pub_hi} + {1'b0, pub_lo};
        end
      end
    end
  end

  assign mon.high_len   = high_len_q;
  assign mon.low_len    = low_len_q;
  assign mon.period_len = period_len_q;
  assign mon.meas_valid = meas_valid_q;
  assign mon.duty_err   = duty_err_q;
  assign mon.period_err = period_err_q;
  assign mon.locked     = locked_q;
  assign mon.stuck      = stuck_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed self-checking bench for div_clk_monitor
module tb_div_clk_monitor;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;

  div_mon_if #(.CNT_W(CW)) m ();

  div_clk_monitor #(.CNT_W(CW), .LOCK_CNT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (m)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi, lo;                  // driven high/low half-cycles
    int xh, xl, xp, xd, xpe, xlk; // expected publish of this period
  } vec_t;

  typedef struct {
    int hl, ll, pl, de, pe, lk, cyc;
  } pub_t;

  vec_t vecs [0:27];
  pub_t pubs [$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m.meas_valid) begin
      pub_t p;
      p.hl  = int'(m.high_len);
      p.ll  = int'(m.low_len);
      p.pl  = int'(m.period_len);
      p.de  = int'(m.duty_err);
      p.pe  = int'(m.period_err);
      p.lk  = int'(m.locked);
      p.cyc = cyc;
      pubs.push_back(p);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int hi, input int lo, input int xh, input int xl,
                         input int xp, input int xd, input int xpe, input int xlk);
    vecs[i] = '{hi, lo, xh, xl, xp, xd, xpe, xlk};
  endtask

  task automatic half(input logic v);
    @(clk);
    #1;
    m.clk_div = v;
  endtask

  task automatic period(input int hi, input int lo);
    repeat (hi) half(1'b1);
    repeat (lo) half(1'b0);
  endtask

  task automatic prep(input int eh, input int el);
    m.en = 1'b0;
    repeat (4) half(1'b0);
    m.exp_high = CW'(eh);
    m.exp_low  = CW'(el);
    pubs.delete();
    m.en = 1'b1;
    repeat (2) half(1'b0);
  endtask

  task automatic drive_rows(input int s, input int n);
    for (int i = 0; i < n; i++) period(vecs[s+i].hi, vecs[s+i].lo);
  endtask

  task automatic check_pub(input string tag, input int j, input pub_t p, input vec_t v);
    chk($sformatf("%s[%0d] high_len", tag, j), p.hl, v.xh);
    chk($sformatf("%s[%0d] low_len", tag, j), p.ll, v.xl);
    chk($sformatf("%s[%0d] period_len", tag, j), p.pl, v.xp);
    chk($sformatf("%s[%0d] duty_err", tag, j), p.de, v.xd);
    chk($sformatf("%s[%0d] period_err", tag, j), p.pe, v.xpe);
    chk($sformatf("%s[%0d] locked", tag, j), p.lk, v.xlk);
  endtask

  // Trailing rise publishes the last row, then compare everything collected.
  task automatic finish_check(input string tag, input int s, input int n);
    half(1'b1);
    half(1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, " publish count"}, pubs.size(), n);
    for (int j = 0; j < n; j++)
      if (j < pubs.size()) check_pub(tag, j, pubs[j], vecs[s+j]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " high_len"}, int'(m.high_len), 0);
    chk({tag, " low_len"}, int'(m.low_len), 0);
    chk({tag, " period_len"}, int'(m.period_len), 0);
    chk({tag, " meas_valid"}, int'(m.meas_valid), 0);
    chk({tag, " duty_err"}, int'(m.duty_err), 0);
    chk({tag, " period_err"}, int'(m.period_err), 0);
    chk({tag, " locked"}, int'(m.locked), 0);
    chk({tag, " stuck"}, int'(m.stuck), 0);
  endtask

  initial begin
    // A: 3/4 lock, one 4/4 glitch, re-lock
    for (int i = 0; i < 5; i++) set_vec(i, 3, 4, 3, 4, 7, 0, 0, (i >= 3) ? 1 : 0);
    set_vec(5, 4, 4, 4, 4, 8, 1, 1, 0);
    for (int i = 6; i < 10; i++) set_vec(i, 3, 4, 3, 4, 7, 0, 0, (i == 9) ? 1 : 0);
    // B: 1/1, clk_div follows clk
    for (int i = 10; i < 16; i++) set_vec(i, 1, 1, 1, 1, 2, 0, 0, (i >= 13) ? 1 : 0);
    // C: exp 5/2, a swapped 2/5 period is a duty error with a correct period
    set_vec(16, 5, 2, 5, 2, 7, 0, 0, 0);
    set_vec(17, 5, 2, 5, 2, 7, 0, 0, 0);
    set_vec(18, 2, 5, 2, 5, 7, 1, 0, 0);
    set_vec(19, 5, 2, 5, 2, 7, 0, 0, 0);
    // D: re-lock after en returns
    for (int i = 20; i < 26; i++) set_vec(i, 3, 4, 3, 4, 7, 0, 0, (i >= 23) ? 1 : 0);
    // E: after reset
    set_vec(26, 3, 4, 3, 4, 7, 0, 0, 0);
    set_vec(27, 3, 4, 3, 4, 7, 0, 0, 0);

    m.en = 1'b0;
    m.clk_div = 1'b0;
    m.exp_high = '0;
    m.exp_low = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    prep(3, 4);
    drive_rows(0, 10);
    finish_check("A", 0, 10);

    prep(1, 1);
    drive_rows(10, 6);
    finish_check("B", 10, 6);
    for (int j = 1; j < pubs.size(); j++)
      chk($sformatf("B[%0d] publish gap cycles", j), pubs[j].cyc - pubs[j-1].cyc, 1);

    prep(5, 2);
    drive_rows(16, 4);
    finish_check("C", 16, 4);

    // Stuck low
    prep(3, 4);
    repeat (5) period(3, 4);
    repeat (200) half(1'b0);
    chk("stuck before saturation", int'(m.stuck), 0);
    chk("stuck pre publish count", pubs.size(), 4);
    if (pubs.size() >= 4) chk("stuck pre locked", pubs[3].lk, 1);
    repeat (100) half(1'b0);
    chk("stuck set", int'(m.stuck), 1);
    chk("stuck locked", int'(m.locked), 0);
    period(3, 4);
    chk("stuck released", int'(m.stuck), 0);
    chk("stuck release no publish", pubs.size(), 4);
    half(1'b1);
    half(1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("stuck resume count", pubs.size(), 5);
    if (pubs.size() >= 5) check_pub("stuck resume", 4, pubs[4], vecs[26]);

    // Reset in the middle of a high phase while locked
    prep(3, 4);
    repeat (5) period(3, 4);
    half(1'b1);
    half(1'b1);
    chk("pre-reset locked", int'(m.locked), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid reset");
    pubs.delete();
    half(1'b1);
    half(1'b0);
    half(1'b0);
    #2 rst_n = 1'b1;
    half(1'b0);
    half(1'b0);
    drive_rows(26, 1);
    chk("E no publish on first rise", pubs.size(), 0);
    drive_rows(27, 1);
    finish_check("E", 26, 2);

    // en dropped during traffic
    prep(3, 4);
    repeat (5) period(3, 4);
    chk("pre-en locked", int'(m.locked), 1);
    m.en = 1'b0;
    repeat (3) period(3, 4);
    chk("en0 locked", int'(m.locked), 0);
    chk("en0 stuck", int'(m.stuck), 0);
    chk("en0 high_len hold", int'(m.high_len), 3);
    chk("en0 low_len hold", int'(m.low_len), 4);
    chk("en0 period_len hold", int'(m.period_len), 7);
    chk("en0 no publish", pubs.size(), 4);
    pubs.delete();
    m.en = 1'b1;
    drive_rows(20, 6);
    finish_check("D", 20, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Downstream checker for the fractional clock dividers (N.5 family, e.g. divide-by-3.5).
- Samples the divided clock clk_div on both edges of the source clk and measures its high time, low time and period in half-cycles of clk.
- Compares each measured period against programmed expectations, raises duty/period errors, and declares lock after a run of good periods.
- Used in-system and in benches to qualify divider output; all counting logic runs on posedge clk.

Parameters:
CNT_W, 8, width of half-cycle run counters; saturation value is 2^CNT_W-1.
LOCK_CNT, 4, consecutive matching periods required to assert locked.

Ports:
clk  input  1  source clock (same clock that feeds the divider)
rst_n  input  1  asynchronous active-low reset
en  input  1  monitor enable, sampled on posedge clk
clk_div  input  1  divided clock under test; transitions are aligned to clk edges
exp_high  input  CNT_W  expected high time in half-cycles
exp_low  input  CNT_W  expected low time in half-cycles
high_len  output  CNT_W  last measured high time in half-cycles
low_len  output  CNT_W  last measured low time in half-cycles
period_len  output  CNT_W+1  high_len+low_len
meas_valid  output  1  one-cycle pulse when a new measurement is published
duty_err  output  1  one-cycle pulse with meas_valid when high_len!=exp_high or low_len!=exp_low
period_err  output  1  one-cycle pulse with meas_valid when period_len!=exp_high+exp_low
locked  output  1  level: LOCK_CNT consecutive error-free periods seen
stuck  output  1  level: current run counter saturated with no transition

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All outputs are 0; sampler, run counter, arm flag and lock counter are all 0.
- Sampling:
  - s_n: clk_div captured on negedge clk, giving the value during the clk-high phase.
  - s_p: clk_div captured on posedge clk, giving the value during the clk-low phase.
  - At each posedge the pair {h=s_n, l=s_p} is processed in time order h then l, against prev, the last processed sample.
- Stream processing (two samples per clk cycle, resolved combinationally, registered at posedge):
  - Equal to the previous sample: run counter +1, saturating at 2^CNT_W-1.
  - Differs from the previous sample: the finished run length is latched into hi_acc or lo_acc, and the run counter restarts at 1.
  - Both a rise and a fall inside one pair are supported, so a minimum high or low time of 1 half-cycle is legal.
- Arming and publishing:
  - The first rising transition after reset, en rising, or stuck sets armed and publishes nothing.
  - Each later rising transition publishes: high_len=hi_acc, low_len=length of the low run just ended, period_len=their sum.
  - meas_valid, duty_err and period_err are registered and asserted in the clk cycle following the posedge whose sample pair contained the rising transition.
  - At most one publish per cycle (guaranteed because the minimum period is 2 half-cycles).
- Lock:
  - A publish with no error increments the lock counter, saturating at LOCK_CNT; locked=1 when the counter reaches LOCK_CNT.
  - Any error clears the lock counter and locked in the same cycle as meas_valid.
- Stuck:
  - stuck=1 from the cycle the run counter reaches saturation.
  - Stuck also clears armed, the lock counter and locked.
  - stuck=0 on the next transition; that transition does not publish, since re-arming needs a rising transition.
- en=0:
  - Synchronously clears armed, the run counter, the lock counter, locked, stuck and all pulses.
  - high_len, low_len and period_len hold their last values.
  - Sampling continues so that prev stays current.
- Reset mid-measurement: everything returns to reset values immediately; no partial period is published.

Decomposition:
- Package div_mon_pkg holds:
  - default CNT_W and LOCK_CNT constants;
  - typedef half_cnt_t (logic [CNT_W-1:0]);
  - typedef sample_pair_t struct {h, l};
  - function sat_inc.
- Sub-module div_mon_sampler: negedge/posedge capture of clk_div, emitting sample_pair_t each posedge.
- Run-length, publish and lock logic stays in the top module.

Test Plan:
1. Divider model giving high 3, low 4 half-cycles (3.5 "3443" style), exp_high=3, exp_low=4 -> after the first period, meas_valid once per 3.5 clk cycles with 3/4/7; no errors; locked=1 at the 4th publish.
2. Model giving high 1, low 1 (clk_div follows clk), exp 1/1 -> rise and fall in every pair, meas_valid every cycle with 1/1/2, locked after 4 cycles.
3. Locked on 3/4, then inject one 4/4 period -> that publish shows 4/4/8 with duty_err=1 and period_err=1; locked falls; re-locks after 4 good periods.
4. Hold clk_div=0 for 300 half-cycles, CNT_W=8 -> stuck=1 once the run reaches 255, locked=0; on release, the first rise does not publish; meas_valid resumes one period later.
5. Assert rst_n low mid-high-phase while locked -> all outputs 0 immediately; after release, no meas_valid until two rising transitions have been seen.
6. Drop en for 10 cycles during 3/4 traffic -> pulses suppressed, lengths hold 3/4/7, locked=0; re-lock 4 periods after the first publish following en=1.
